drp_arbiter: RTL

Round-robin arbiter that shares one GT DRP port between NUM_REQ 10GBASE-R PCS/PMA cores (master + slave instances on a shared QPLL quad). It implements the cores' drp_req/drp_gnt handshake, forwards the granted core's DRP transaction to the transceiver, and returns the response to that core only. A per-access timeout guarantees a hung DRP never locks a core out; timeouts are counted for VIO observation.

---
 rtl/drp_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/drp_arbiter.sv
// drp_arbiter: round-robin sharing of one GT DRP port between NUM_REQ PCS/PMA
// cores. Implements the drp_req/drp_gnt handshake, forwards the grantee's DRP
// access, routes the response back to that core only and bounds every access
// with a timeout so a hung DRP cannot lock a core out.
module drp_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                       dclk,
  input  logic                       areset,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  input  logic [NUM_REQ-1:0]         den_i,
  input  logic [NUM_REQ-1:0]         dwe_i,
  input  logic [16*NUM_REQ-1:0]      daddr_i,
  input  logic [16*NUM_REQ-1:0]      di_i,
  output logic [NUM_REQ-1:0]         drdy_o,
  output logic [15:0]                drpdo_o,
  output logic                       gt_den,
  output logic                       gt_dwe,
  output logic [15:0]                gt_daddr,
  output logic [15:0]                gt_di,
  input  logic                       gt_drdy,
  input  logic [15:0]                gt_drpdo,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy,
  output logic [7:0]                 timeout_cnt
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, GRANT, ACCESS} state_t;

  state_t               state_reg, state_next;
  logic [OW-1:0]        owner_reg, owner_next;
  logic [NUM_REQ-1:0]   gnt_reg, gnt_next;
  logic [NUM_REQ-1:0]   drdy_reg, drdy_next;
  logic [15:0]          drpdo_reg, drpdo_next;
  logic                 gt_den_reg, gt_den_next;
  logic                 gt_dwe_reg, gt_dwe_next;
  logic [15:0]          gt_daddr_reg, gt_daddr_next;
  logic [15:0]          gt_di_reg, gt_di_next;
  logic [TW-1:0]        timer_reg, timer_next;
  logic [7:0]           tcnt_reg, tcnt_next;
  logic                 busy_reg;
  logic                 done;
  logic [OW-1:0]        winner;

  // Per-core views of the packed address/data buses
  logic [15:0] daddr_arr [NUM_REQ];
  logic [15:0] di_arr    [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign daddr_arr[gi] = daddr_i[16*gi +: 16];
      assign di_arr[gi]    = di_i[16*gi +: 16];
    end
  endgenerate

  // Round-robin winner: first active request after the last grantee
  always_comb begin
    logic [OW-1:0] cur;
    logic          found;
    winner = owner_reg;
    cur    = owner_reg;
    found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cur = (cur == OW'(NUM_REQ - 1)) ? '0 : cur + 1'b1;
      if (!found && req[cur]) begin
        winner = cur;
        found  = 1'b1;
      end
    end
  end

  // Next-state and next-output logic for the IDLE/GRANT/ACCESS handshake
  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    gnt_next      = gnt_reg;
    drdy_next     = '0;
    drpdo_next    = drpdo_reg;
    gt_den_next   = 1'b0;
    gt_dwe_next   = 1'b0;
    gt_daddr_next = gt_daddr_reg;
    gt_di_next    = gt_di_reg;
    timer_next    = timer_reg;
    tcnt_next     = tcnt_reg;
    done          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          owner_next       = winner;
          gnt_next         = '0;
          gnt_next[winner] = 1'b1;
          state_next       = GRANT;
        end
      end
      GRANT: begin
        // A strobe in the same cycle as the request drop still gets served
        if (den_i[owner_reg]) begin
          gt_den_next   = 1'b1;
          gt_dwe_next   = dwe_i[owner_reg];
          gt_daddr_next = daddr_arr[owner_reg];
          gt_di_next    = di_arr[owner_reg];
          timer_next    = '0;
          state_next    = ACCESS;
        end else if (!req[owner_reg]) begin
          gnt_next   = '0;
          state_next = IDLE;
        end
      end
      ACCESS: begin
        timer_next = timer_reg + 1'b1;
        if (gt_drdy) begin
          drpdo_next = gt_drpdo;
          done       = 1'b1;
        end else if (timer_reg == TW'(TIMEOUT - 1)) begin
          // Synthetic completion so the core never waits forever
          drpdo_next = 16'h0000;
          if (tcnt_reg != 8'hFF) tcnt_next = tcnt_reg + 8'd1;
          done       = 1'b1;
        end
        if (done) begin
          drdy_next[owner_reg] = 1'b1;
          if (req[owner_reg]) begin
            state_next = GRANT;
          end else begin
            gnt_next   = '0;
            state_next = IDLE;
          end
        end
      end
      default: begin
        gnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any access without a response
  always_ff @(posedge dclk or posedge areset) begin
    if (areset) begin
      state_reg    <= IDLE;
      owner_reg    <= OW'(NUM_REQ - 1);
      gnt_reg      <= '0;
      drdy_reg     <= '0;
      drpdo_reg    <= '0;
      gt_den_reg   <= 1'b0;
      gt_dwe_reg   <= 1'b0;
      gt_daddr_reg <= '0;
      gt_di_reg    <= '0;
      timer_reg    <= '0;
      tcnt_reg     <= '0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      gnt_reg      <= gnt_next;
      drdy_reg     <= drdy_next;
      drpdo_reg    <= drpdo_next;
      gt_den_reg   <= gt_den_next;
      gt_dwe_reg   <= gt_dwe_next;
      gt_daddr_reg <= gt_daddr_next;
      gt_di_reg    <= gt_di_next;
      timer_reg    <= timer_next;
      tcnt_reg     <= tcnt_next;
      busy_reg     <= (state_next != IDLE);
    end
  end

  assign gnt         = gnt_reg;
  assign drdy_o      = drdy_reg;
  assign drpdo_o     = drpdo_reg;
  assign gt_den      = gt_den_reg;
  assign gt_dwe      = gt_dwe_reg;
  assign gt_daddr    = gt_daddr_reg;
  assign gt_di       = gt_di_reg;
  assign owner       = owner_reg;
  assign busy        = busy_reg;
  assign timeout_cnt = tcnt_reg;

endmodule
